// File: rtl/azimuth_signal_generator_pkg.sv
// Shared constants for the azimuth signal generator.
// Default sweep length matches one 3.2 ms sweep at 1 MHz.
package azimuth_signal_generator_pkg;

    localparam int DEFAULT_SIZE = 3200;

    // Bits needed to count 0..size inclusive.
    function automatic int cnt_width(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/azimuth_signal_generator_rise_edge_detect.sv
// One-register rising-edge detector for the sweep trigger.
// History register updates every cycle, independent of enable.
module rise_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Remember last cycle's level of the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            d_q <= 1'b0;
        else
            d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/azimuth_signal_generator.sv
// Serialises a SIZE-bit azimuth pattern, LSB first, one bit per clock,
// starting at each enabled rising edge of TRIG.
module azimuth_signal_generator
    import azimuth_signal_generator_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            TRIG,
    input  logic [SIZE-1:0] DATA,
    output logic            SIGNAL
);

    localparam int CW = cnt_width(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic            trig_rise;
    logic            start;
    logic            active;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] sh;

    rise_edge_detect u_trig_edge (
        .clk  (CLK),
        .rst  (RST),
        .d    (TRIG),
        .rise (trig_rise)
    );

    assign start = EN & trig_rise;

    // Sweep control: load on start, shift while active, stop at SIZE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sh     <= '0;
            cnt    <= '0;
            active <= 1'b0;
            SIGNAL <= 1'b0;
        end else if (!EN) begin
            cnt    <= '0;
            active <= 1'b0;
            SIGNAL <= 1'b0;
        end else if (start) begin
            sh     <= DATA;
            cnt    <= ONE;
            active <= 1'b1;
            SIGNAL <= DATA[0];
        end else if (active) begin
            if (cnt == LAST) begin
                cnt    <= '0;
                active <= 1'b0;
                SIGNAL <= 1'b0;
            end else begin
                sh     <= sh >> 1;
                cnt    <= cnt + ONE;
                SIGNAL <= sh[1];
            end
        end else begin
            SIGNAL <= 1'b0;
        end
    end

endmodule

// File: tb/tb_azimuth_signal_generator.sv
// Self-checking bench: two instances (3200-bit and 8-bit sweeps)
// against a positional reference model plus literal expectations.
`timescale 1ns/1ps
module tb_azimuth_signal_generator;

    localparam int BIG = 3200;
    localparam int SML = 8;

    logic            clk;
    logic            rst;
    logic            en   [2];
    logic            trig [2];
    logic [BIG-1:0]  dat  [2];
    logic            sig  [2];

    int checks;
    int failures;

    // Reference model state: sweep position (-1 idle).
    int             pos   [2];
    logic [BIG-1:0] cap   [2];
    logic           tq    [2];
    logic           exp_s [2];
    int             sz    [2];

    azimuth_signal_generator #(.SIZE(BIG)) dut0 (
        .CLK    (clk),
        .RST    (rst),
        .EN     (en[0]),
        .TRIG   (trig[0]),
        .DATA   (dat[0]),
        .SIGNAL (sig[0])
    );

    azimuth_signal_generator #(.SIZE(SML)) dut1 (
        .CLK    (clk),
        .RST    (rst),
        .EN     (en[1]),
        .TRIG   (trig[1]),
        .DATA   (dat[1][SML-1:0]),
        .SIGNAL (sig[1])
    );

    // 1 MHz clock.
    initial clk = 1'b0;
    always #500 clk = ~clk;

    task automatic chk(input string name, input logic act,
                       input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b expected %b @%0t",
                     name, act, req, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act,
                           input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d @%0t",
                     name, act, req, $time);
        end
    endtask

    // Model: a sweep is "which bit index of captured data is shown".
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < 2; u++) begin
                pos[u]   = -1;
                tq[u]    = 1'b0;
                exp_s[u] = 1'b0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (en[u] && trig[u] && !tq[u]) begin
                    cap[u] = dat[u];
                    pos[u] = 0;
                end else if (!en[u]) begin
                    pos[u] = -1;
                end else if (pos[u] >= 0) begin
                    pos[u]++;
                    if (pos[u] >= sz[u])
                        pos[u] = -1;
                end
                tq[u]    = trig[u];
                exp_s[u] = (pos[u] >= 0) ? cap[u][pos[u]] : 1'b0;
            end
        end
    end

    // Compare DUTs against the model just after every edge.
    always @(posedge clk) begin
        #1;
        chk("model_sig0", sig[0], exp_s[0]);
        chk("model_sig1", sig[1], exp_s[1]);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse TRIG then sample n bits; report high count and extents.
    task automatic sweep(input int u, input int n, output int hi,
                         output int first_hi, output int last_hi);
        hi       = 0;
        first_hi = -1;
        last_hi  = -1;
        trig[u]  = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            trig[u] = 1'b0;
            if (sig[u]) begin
                hi++;
                if (first_hi < 0)
                    first_hi = i;
                last_hi = i;
            end
        end
    endtask

    logic [8:0]  seq_a;
    logic [11:0] seq_b;
    int hi, fh, lh;

    initial begin
        checks   = 0;
        failures = 0;
        sz[0]    = BIG;
        sz[1]    = SML;
        rst      = 1'b1;
        for (int u = 0; u < 2; u++) begin
            en[u]   = 1'b0;
            trig[u] = 1'b0;
            dat[u]  = '0;
        end
        tick(3);
        chk("reset_sig0", sig[0], 1'b0);
        chk("reset_sig1", sig[1], 1'b0);
        rst = 1'b0;
        tick(2);

        // Half pattern: 1600 ones then 1600 zeros.
        dat[0] = {{1600{1'b0}}, {1600{1'b1}}};
        en[0]  = 1'b1;
        tick(1);
        sweep(0, 3300, hi, fh, lh);
        chk_int("half_hi", hi, 1600);
        chk_int("half_first", fh, 0);
        chk_int("half_last", lh, 1599);

        // Inverted pattern after cycling enable.
        en[0] = 1'b0;
        tick(3);
        dat[0] = ~dat[0];
        en[0]  = 1'b1;
        tick(2);
        sweep(0, 3300, hi, fh, lh);
        chk_int("inv_hi", hi, 1600);
        chk_int("inv_first", fh, 1600);
        chk_int("inv_last", lh, 3199);

        // Async reset mid-sweep, away from a clock edge.
        dat[0] = {BIG{1'b1}};
        sweep(0, 500, hi, fh, lh);
        chk("pre_reset_hi", sig[0], 1'b1);
        #200;
        rst = 1'b1;
        #1;
        chk("async_reset", sig[0], 1'b0);
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            chk("post_reset_idle", sig[0], 1'b0);
        end

        // Bit order and latency on the 8-bit instance.
        seq_a  = 9'b0_1011_0010;
        dat[1] = '0;
        dat[1][7:0] = 8'b1011_0010;
        en[1]  = 1'b1;
        tick(1);
        trig[1] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            trig[1] = 1'b0;
            chk("bit_order", sig[1], seq_a[i]);
        end
        tick(3);

        // Retrigger at k+3 with DATA changed mid-sweep.
        seq_b = {1'b0, 8'b0110_1111, 3'b010};
        trig[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            trig[1] = (i == 2);
            if (i == 1)
                dat[1][7:0] = 8'b0110_1111;
            chk("retrigger", sig[1], seq_b[i]);
        end
        tick(3);

        // Enable gating: TRIG high as EN rises does not start.
        en[1]   = 1'b0;
        dat[1][7:0] = 8'hFF;
        trig[1] = 1'b1;
        tick(1);
        en[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("en_rise_no_start", sig[1], 1'b0);
        end
        trig[1] = 1'b0;
        tick(1);
        trig[1] = 1'b1;
        tick(1);
        chk("en_sweep_b0", sig[1], 1'b1);
        tick(1);
        chk("en_sweep_b1", sig[1], 1'b1);
        en[1] = 1'b0;
        tick(1);
        chk("en_drop", sig[1], 1'b0);
        en[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("no_resume", sig[1], 1'b0);
        end

        // Random stimulus on both instances.
        for (int i = 0; i < 4000; i++) begin
            en[1]   = ($urandom_range(0, 15) != 0);
            trig[1] = $urandom_range(0, 1) != 0;
            dat[1][7:0] = 8'($urandom);
            en[0]   = ($urandom_range(0, 200) != 0);
            trig[0] = ($urandom_range(0, 300) == 0);
            dat[0][31:0] = $urandom;
            tick(1);
        end
        en[0]   = 1'b0;
        en[1]   = 1'b0;
        trig[0] = 1'b0;
        trig[1] = 1'b0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
